// File: rtl/icode_fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icode_fetch_pkg
// Description : Shared types and default constants for the LU instruction
//               fetch unit: FSM state encoding, instruction word type and
//               default NOP / HALT opcodes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package icode_fetch_pkg;

  localparam int ICODE_W = 8;

  typedef logic [ICODE_W-1:0] icode_word_t;

  // HALTED is only reachable when the halt feature is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam icode_word_t DEFAULT_NOP_CODE    = 8'h00;
  localparam icode_word_t DEFAULT_HALT_OPCODE = 8'hFF;

endpackage : icode_fetch_pkg
`default_nettype wire

// File: rtl/icode_fetch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icode_fetch_if
// Description : Bundles the control, memory read port and ICODE handshake
//               signals of the fetch unit.
// Ports       : start, redirect, redirect_addr  - sequencing controls
//               mem_rd_en, mem_rd_addr, mem_rd_data - instruction memory port
//               icode, icode_valid, icode_ready - processor handshake
//               pc, busy - status
//               modport master : fetch unit side
//               modport slave  : processor / memory / environment side
// Revision    : 1.0 - initial release
// ============================================================================
interface icode_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              start;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] icode;
  logic              icode_valid;
  logic              icode_ready;
  logic [ADDR_W-1:0] pc;
  logic              busy;

  modport master (
    input  start, redirect, redirect_addr, mem_rd_data, icode_ready,
    output mem_rd_en, mem_rd_addr, icode, icode_valid, pc, busy
  );

  modport slave (
    output start, redirect, redirect_addr, mem_rd_data, icode_ready,
    input  mem_rd_en, mem_rd_addr, icode, icode_valid, pc, busy
  );

endinterface : icode_fetch_if
`default_nettype wire

// File: rtl/icode_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icode_fifo
// Description : Small synchronous prefetch FIFO. Same-cycle push and pop are
//               supported; flush has priority over push and pop. The head
//               word is read straight out of the storage array.
// Ports       : clk, rst (sync, active-low)
//               i_push, i_push_data - write side
//               i_pop               - remove head entry
//               i_flush             - discard all entries
//               o_count             - number of stored entries
//               o_head              - entry at the head (meaningless if empty)
// Revision    : 1.0 - initial release
// ============================================================================
module icode_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [CNT_W-1:0]  o_count,
  output logic [DATA_W-1:0] o_head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full FIFO can still accept a word if the head leaves this cycle.
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the count masks stale entries.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule : icode_fifo
`default_nettype wire

// File: rtl/icode_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icode_fetch_unit
// Description : Instruction fetch unit for the LU processor. Owns the program
//               counter, issues reads to the synchronous instruction memory,
//               buffers returned words in a prefetch FIFO and streams them to
//               ICODE over a valid/ready handshake. A redirect flushes the
//               FIFO, squashes the in-flight read and reloads the PC.
//               Optional halt support: define ICODE_FETCH_HALT_EN.
// Ports       : clk, rst (sync, active-low)
//               fetch (icode_fetch_if.master):
//                 start, redirect, redirect_addr -> sequencing
//                 mem_rd_en, mem_rd_addr, mem_rd_data -> memory read port
//                 icode, icode_valid, icode_ready -> processor handshake
//                 pc, busy -> status
// Revision    : 1.0 - initial release
// ============================================================================
module icode_fetch_unit
  import icode_fetch_pkg::*;
#(
  parameter int              ADDR_W      = 8,
  parameter int              DATA_W      = 8,
  parameter int              FIFO_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [DATA_W-1:0] NOP_CODE    = DATA_W'(DEFAULT_NOP_CODE),
  parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(DEFAULT_HALT_OPCODE)
) (
  input  logic         clk,
  input  logic         rst,
  icode_fetch_if.master fetch
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  // Memory latency is one cycle, so at most one read is ever outstanding.
  logic              r_inflight;
  logic              w_inflight_nxt;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_level;
  logic [DATA_W-1:0] w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_halt_hit;
  logic              w_valid;

  // Returning data is dropped when a redirect lands on the same edge.
  assign w_push  = r_inflight && !fetch.redirect;
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && fetch.icode_ready;

`ifdef ICODE_FETCH_HALT_EN
  assign w_halt_hit = w_push && (fetch.mem_rd_data == HALT_OPCODE);
`else
  assign w_halt_hit = 1'b0;
  logic w_unused_halt;
  assign w_unused_halt = ^HALT_OPCODE;
`endif

  // Occupancy counts reserved slots too, so the FIFO can never overflow.
  assign w_level = w_count + CNT_W'(r_inflight);
  assign w_issue = (r_state == ST_RUN) && (w_level < CNT_W'(FIFO_DEPTH)) && !w_halt_hit;

  icode_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (fetch.mem_rd_data),
    .i_pop       (w_pop),
    .i_flush     (fetch.redirect),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= START_ADDR;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_inflight_nxt = w_issue;

    if (w_issue) w_pc_nxt = r_pc + 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (fetch.start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // The halt word is pushed this edge; the PC already points past it
        // because issue is suppressed in the same cycle.
        if (w_halt_hit) w_state_nxt = ST_HALTED;
      end
`ifdef ICODE_FETCH_HALT_EN
      ST_HALTED: begin
        if (fetch.start || fetch.redirect) w_state_nxt = ST_RUN;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    // Redirect overrides the PC and squashes a read issued this cycle.
    if (fetch.redirect) begin
      w_pc_nxt       = fetch.redirect_addr;
      w_inflight_nxt = 1'b0;
    end
  end

  assign fetch.mem_rd_en   = w_issue;
  assign fetch.mem_rd_addr = r_pc;
  assign fetch.pc          = r_pc;
  assign fetch.busy        = (r_state == ST_RUN);
  assign fetch.icode_valid = w_valid;
  assign fetch.icode       = w_valid ? w_head : NOP_CODE;

endmodule : icode_fetch_unit
`default_nettype wire

// File: tb/tb_icode_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_icode_fetch_unit
// Description : Self-checking bench for icode_fetch_unit. A behavioural model
//               tracks the address of the next instruction the processor
//               should receive and compares every accepted word with the
//               memory image. Directed scenarios cover start latency,
//               back-pressure, redirect flush, PC wrap, reset and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icode_fetch_unit;
  import icode_fetch_pkg::*;

  localparam int         ADDR_W     = 8;
  localparam int         DATA_W     = 8;
  localparam int         FIFO_DEPTH = 4;
  localparam logic [7:0] START_ADDR = 8'h00;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  icode_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  icode_fetch_unit #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .START_ADDR  (START_ADDR),
    .NOP_CODE    (DEFAULT_NOP_CODE),
    .HALT_OPCODE (DEFAULT_HALT_OPCODE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus)
  );

  icode_word_t mem [0:255];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_issue  = 0;
  int         n_deliv  = 0;
  int         mode     = M_IDLE;
  int         age      = 100;
  logic [7:0] exp_addr = START_ADDR;
  bit         hold_pend;
  logic [7:0] hold_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, predict what the coming edge does, then check
  // the outputs on the following falling edge.
  task automatic drive_cycle(input bit st, input bit rd, input logic [7:0] ra, input bit rdy);
    bus.start = st; bus.redirect = rd; bus.redirect_addr = ra; bus.icode_ready = rdy;
    #1;
    if (bus.mem_rd_en) n_issue++;
    hold_pend = bus.icode_valid && !rdy && !rd;
    hold_val  = bus.icode;
    if (bus.icode_valid && rdy) begin
      check_eq("data", {24'd0, bus.icode}, {24'd0, mem[exp_addr]});
`ifdef ICODE_FETCH_HALT_EN
      if (bus.icode == DEFAULT_HALT_OPCODE && mode == M_RUN) mode = M_HALT;
`endif
      exp_addr++;
      n_deliv++;
    end
    if (rd || (st && mode != M_RUN)) age = 0;
    if (st && mode == M_IDLE) mode = M_RUN;
    if ((st || rd) && mode == M_HALT) mode = M_RUN;
    if (rd) exp_addr = ra;
    @(negedge clk);
    if (age < 100) age++;
    if (hold_pend) check_eq("hold", {24'd0, bus.icode}, {24'd0, hold_val});
    if (!bus.icode_valid) check_eq("nop", {24'd0, bus.icode}, {24'd0, DEFAULT_NOP_CODE});
    if (bus.busy && age >= 3) check_eq("stream_valid", {31'd0, bus.icode_valid}, 32'd1);
`ifndef ICODE_FETCH_HALT_EN
    check_eq("busy", {31'd0, bus.busy}, {31'd0, mode == M_RUN});
`endif
  endtask

  task automatic do_reset_check();
    rst = 1'b0;
    bus.start = 1'b0; bus.redirect = 1'b0; bus.redirect_addr = '0; bus.icode_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", {31'd0, bus.icode_valid}, 32'd0);
    check_eq("rst_icode", {24'd0, bus.icode}, {24'd0, DEFAULT_NOP_CODE});
    check_eq("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    check_eq("rst_rd_addr", {24'd0, bus.mem_rd_addr}, {24'd0, START_ADDR});
    check_eq("rst_pc", {24'd0, bus.pc}, {24'd0, START_ADDR});
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b1;
    mode = M_IDLE; exp_addr = START_ADDR; age = 100;
  endtask

  int d0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    // Start latency and first four words.
    do_reset_check();
    d0 = n_deliv;
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check_eq("first_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
    check_eq("lat_e0_valid", {31'd0, bus.icode_valid}, 32'd0);
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("lat_e1_valid", {31'd0, bus.icode_valid}, 32'd0);
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("lat_e2_valid", {31'd0, bus.icode_valid}, 32'd1);
    check_eq("lat_e2_icode", {24'd0, bus.icode}, 32'h11);
    repeat (4) drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("first_four", n_deliv - d0, 32'd4);

    // Back-pressure: reads stop at four outstanding words.
    do_reset_check();
    n_issue = 0;
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (10) drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("bp_issues", n_issue, 32'd4);
    check_eq("bp_icode", {24'd0, bus.icode}, 32'h11);
    check_eq("bp_pc", {24'd0, bus.pc}, 32'h04);
    repeat (5) drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Redirect with three buffered words and one in flight.
    do_reset_check();
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (4) drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
    drive_cycle(1'b0, 1'b1, 8'h80, 1'b0);
    check_eq("redir_flush", {31'd0, bus.icode_valid}, 32'd0);
    check_eq("redir_pc", {24'd0, bus.mem_rd_addr}, 32'h80);
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("redir_first", {24'd0, bus.icode}, {24'd0, mem[8'h80]});
    repeat (4) drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // PC wrap.
    d0 = n_deliv;
    drive_cycle(1'b0, 1'b1, 8'hFE, 1'b1);
    repeat (6) drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("wrap_count", n_deliv - d0, 32'd5);

    // Randomized traffic.
    d0 = n_deliv;
    for (int c = 0; c < 600; c++) begin
      drive_cycle(($urandom % 20) == 0, ($urandom % 12) == 0,
                  8'($urandom), ($urandom % 10) < 7);
    end
    check_eq("rand_progress", {31'd0, (n_deliv - d0) > 150}, 32'd1);

    // Reset in the middle of a stream.
    repeat (3) drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    do_reset_check();
    repeat (3) drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("post_rst_idle", {31'd0, bus.mem_rd_en}, 32'd0);

`ifdef ICODE_FETCH_HALT_EN
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'hFF; mem[3] = 8'h04;
    do_reset_check();
    d0 = n_deliv;
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (8) drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("halt_count", n_deliv - d0, 32'd3);
    check_eq("halt_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("halt_pc", {24'd0, bus.pc}, 32'h03);
    check_eq("halt_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check_eq("resume_busy", {31'd0, bus.busy}, 32'd1);
    repeat (3) drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("resume_count", n_deliv - d0, 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_icode_fetch_unit
`default_nettype wire
